// File: rtl/lane_dly_seq_if.sv
// Request channel from the training logic to the DQS delay-line sequencer.
interface lane_dly_seq_if #(parameter int TAP_W = 8);
  logic             REQ_VALID;
  logic             REQ_READY;
  logic             REQ_SEL;
  logic [1:0]       REQ_CMD;
  logic             REQ_DIR;
  logic [TAP_W-1:0] REQ_COUNT;

  modport master (output REQ_VALID, REQ_SEL, REQ_CMD, REQ_DIR, REQ_COUNT,
                  input  REQ_READY);
  modport slave  (input  REQ_VALID, REQ_SEL, REQ_CMD, REQ_DIR, REQ_COUNT,
                  output REQ_READY);
endinterface

// File: rtl/lane_dly_seq.sv
// Sequences MOVE/LOAD pulses onto one lane's RX/TX DQS delay lines with the
// HS IO clock paused around them, and tracks both tap counts.
//
// state  | meaning
// IDLE   | ready for a request
// SETUP  | decode request, pause asserted (or reject with ERR)
// PAUSE  | settle time before the first pulse
// STEP   | one MOVE pulse, or boundary abort
// LOADP  | one LOAD pulse
// GAP    | low time after a pulse, OOR sampled
// FINISH | pause released, DONE or ERR
module lane_dly_seq #(
  parameter int TAP_W     = 8,
  parameter int TAP_MAX   = 255,
  parameter int LOAD_VAL  = 1,
  parameter int PAUSE_CYC = 2,
  parameter int MOVE_GAP  = 3
) (
  input  logic             FAB_CLK,
  input  logic             RESET,
  lane_dly_seq_if.slave    req,
  output logic             DELAY_LINE_SEL,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_LOAD,
  output logic             HS_IO_CLK_PAUSE,
  input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
  input  logic             TX_DELAY_LINE_OUT_OF_RANGE,
  output logic             DONE,
  output logic             ERR,
  output logic [TAP_W-1:0] RX_TAP,
  output logic [TAP_W-1:0] TX_TAP
);
  localparam int CNT_MAX = (PAUSE_CYC > MOVE_GAP) ? PAUSE_CYC : MOVE_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TW1     = TAP_W + 1;
  localparam logic [CNT_W-1:0] PAUSE_LD = CNT_W'(PAUSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(MOVE_GAP - 1);
  localparam logic [TAP_W-1:0] TAP_TOP  = TAP_W'(TAP_MAX);
  localparam logic [TW1-1:0]   TAP_TOPX = TW1'(TAP_MAX);
  localparam logic [TAP_W-1:0] TAP_LOAD = TAP_W'(LOAD_VAL);
  localparam logic [1:0] CMD_MOVE = 2'b00, CMD_LOAD = 2'b01,
                         CMD_SET  = 2'b10, CMD_BAD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PAUSE, S_STEP, S_LOADP, S_GAP, S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAP_W-1:0] rem_q, rem_d;
  logic             cap_sel_q, cap_sel_d, cap_dir_q, cap_dir_d;
  logic [1:0]       cap_cmd_q, cap_cmd_d;
  logic [TAP_W-1:0] cap_cnt_q, cap_cnt_d;
  logic             sel_q, sel_d, dir_q, dir_d, err_q, err_d;
  logic [TAP_W-1:0] rx_tap_q, rx_tap_d, tx_tap_q, tx_tap_d;

  logic             ready;
  logic [TAP_W-1:0] tap_sel, tap_nxt;
  logic             oor_sel, set_dir, reject, new_dir, at_bound;

  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      cap_sel_q <= 1'b0;
      cap_dir_q <= 1'b0;
      cap_cmd_q <= CMD_MOVE;
      cap_cnt_q <= '0;
      sel_q     <= 1'b0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
      rx_tap_q  <= TAP_LOAD;
      tx_tap_q  <= TAP_LOAD;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      cap_sel_q <= cap_sel_d;
      cap_dir_q <= cap_dir_d;
      cap_cmd_q <= cap_cmd_d;
      cap_cnt_q <= cap_cnt_d;
      sel_q     <= sel_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
      rx_tap_q  <= rx_tap_d;
      tx_tap_q  <= tx_tap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    cap_sel_d = cap_sel_q;
    cap_dir_d = cap_dir_q;
    cap_cmd_d = cap_cmd_q;
    cap_cnt_d = cap_cnt_q;
    sel_d     = sel_q;
    dir_d     = dir_q;
    err_d     = err_q;
    rx_tap_d  = rx_tap_q;
    tx_tap_d  = tx_tap_q;

    ready                = 1'b0;
    HS_IO_CLK_PAUSE      = 1'b0;
    DELAY_LINE_MOVE      = 1'b0;
    DELAY_LINE_LOAD      = 1'b0;
    DELAY_LINE_SEL       = sel_q;
    DELAY_LINE_DIRECTION = dir_q;
    DONE                 = 1'b0;
    ERR                  = 1'b0;

    tap_sel  = cap_sel_q ? tx_tap_q : rx_tap_q;
    oor_sel  = cap_sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
    set_dir  = (cap_cnt_q > tap_sel);
    reject   = (cap_cmd_q == CMD_BAD) ||
               ((cap_cmd_q == CMD_SET) && ({1'b0, cap_cnt_q} > TAP_TOPX));
    new_dir  = (cap_cmd_q == CMD_MOVE) ? cap_dir_q :
               (cap_cmd_q == CMD_SET)  ? set_dir   : dir_q;
    at_bound = dir_q ? (tap_sel == TAP_TOP) : (tap_sel == '0);
    tap_nxt  = dir_q ? tap_sel + TAP_W'(1) : tap_sel - TAP_W'(1);

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (req.REQ_VALID) begin
          cap_sel_d = req.REQ_SEL;
          cap_cmd_d = req.REQ_CMD;
          cap_dir_d = req.REQ_DIR;
          cap_cnt_d = req.REQ_COUNT;
          err_d     = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (reject) begin
          // rejected requests leave the delay-line pins exactly as they were
          ERR     = 1'b1;
          state_d = S_IDLE;
        end else begin
          HS_IO_CLK_PAUSE      = 1'b1;
          DELAY_LINE_SEL       = cap_sel_q;
          DELAY_LINE_DIRECTION = new_dir;
          sel_d   = cap_sel_q;
          dir_d   = new_dir;
          cnt_d   = PAUSE_LD;
          state_d = S_PAUSE;
          case (cap_cmd_q)
            CMD_MOVE: rem_d = cap_cnt_q;
            CMD_SET:  rem_d = set_dir ? cap_cnt_q - tap_sel : tap_sel - cap_cnt_q;
            default:  rem_d = '0;
          endcase
        end
      end
      S_PAUSE: begin
        HS_IO_CLK_PAUSE = 1'b1;
        if (cnt_q == '0) begin
          if (cap_cmd_q == CMD_LOAD) state_d = S_LOADP;
          else if (rem_q == '0)      state_d = S_FINISH;
          else                       state_d = S_STEP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STEP: begin
        HS_IO_CLK_PAUSE = 1'b1;
        if (at_bound) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          DELAY_LINE_MOVE = 1'b1;
          if (cap_sel_q) tx_tap_d = tap_nxt;
          else           rx_tap_d = tap_nxt;
          rem_d   = rem_q - TAP_W'(1);
          cnt_d   = GAP_LD;
          state_d = S_GAP;
        end
      end
      S_LOADP: begin
        HS_IO_CLK_PAUSE = 1'b1;
        DELAY_LINE_LOAD = 1'b1;
        if (cap_sel_q) tx_tap_d = TAP_LOAD;
        else           rx_tap_d = TAP_LOAD;
        cnt_d   = GAP_LD;
        state_d = S_GAP;
      end
      S_GAP: begin
        HS_IO_CLK_PAUSE = 1'b1;
        if (oor_sel) err_d = 1'b1;
        if (cnt_q == '0) begin
          if (err_q || oor_sel || (rem_q == '0)) state_d = S_FINISH;
          else                                   state_d = S_STEP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FINISH: begin
        DONE    = ~err_q;
        ERR     = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req.REQ_READY = ready;
  assign RX_TAP        = rx_tap_q;
  assign TX_TAP        = tx_tap_q;
endmodule

// File: tb/tb_lane_dly_seq.sv
// Directed and randomized checks of lane_dly_seq against a cycle-count and
// tap-arithmetic reference model.
module tb_lane_dly_seq;
  localparam int TW   = 9;
  localparam int TMAX = 255;
  localparam int LV   = 1;
  localparam int PC   = 2;
  localparam int G    = 3;

  logic clk = 1'b0;
  logic rst;
  logic sel_o, dir_o, move_o, load_o, pause_o, done_o, err_o;
  logic rx_oor, tx_oor;
  logic [TW-1:0] rx_tap, tx_tap;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int tap_m[2];
  bit sel_last, dir_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lane_dly_seq_if #(.TAP_W(TW)) req_if ();

  lane_dly_seq #(
    .TAP_W(TW), .TAP_MAX(TMAX), .LOAD_VAL(LV), .PAUSE_CYC(PC), .MOVE_GAP(G)
  ) dut (
    .FAB_CLK                   (clk),
    .RESET                     (rst),
    .req                       (req_if),
    .DELAY_LINE_SEL            (sel_o),
    .DELAY_LINE_DIRECTION      (dir_o),
    .DELAY_LINE_MOVE           (move_o),
    .DELAY_LINE_LOAD           (load_o),
    .HS_IO_CLK_PAUSE           (pause_o),
    .RX_DELAY_LINE_OUT_OF_RANGE(rx_oor),
    .TX_DELAY_LINE_OUT_OF_RANGE(tx_oor),
    .DONE                      (done_o),
    .ERR                       (err_o),
    .RX_TAP                    (rx_tap),
    .TX_TAP                    (tx_tap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Model: a request's outcome follows from the step count and the tap walk.
  task automatic run_req(input bit s, input bit [1:0] c, input bit d, input int cnt,
                         input int oor_p, input bit oor_other);
    int  tap, steps, moves, exp_end, exp_loads, pulses, loads, oor_clr_t;
    bit  exp_err, exp_dir, rej, got, prev_move;
    tap = tap_m[s]; moves = 0; exp_err = 0; exp_dir = d; exp_loads = 0;
    rej = (c == 2'b11) || (c == 2'b10 && cnt > TMAX);
    if (rej) begin
      exp_err = 1; exp_end = 1;
    end else if (c == 2'b01) begin
      exp_loads = 1; exp_err = (oor_p == 1); exp_end = 3 + PC + G; tap = LV;
    end else begin
      if (c == 2'b10) begin
        exp_dir = cnt > tap;
        steps = exp_dir ? cnt - tap : tap - cnt;
      end else steps = cnt;
      exp_end = 2 + PC + steps * (1 + G);
      for (int i = 0; i < steps; i++) begin
        if ((exp_dir && tap == TMAX) || (!exp_dir && tap == 0)) begin
          exp_err = 1; exp_end = 3 + PC + i * (1 + G); break;
        end
        tap += exp_dir ? 1 : -1;
        moves++;
        if (moves == oor_p) begin
          exp_err = 1; exp_end = 2 + PC + moves * (1 + G); break;
        end
      end
    end

    @(negedge clk);
    chk("ready_idle", req_if.REQ_READY, 1);
    req_if.REQ_VALID = 1'b1;
    req_if.REQ_SEL   = s;
    req_if.REQ_CMD   = c;
    req_if.REQ_DIR   = d;
    req_if.REQ_COUNT = TW'(cnt);
    if (oor_other) begin
      if (s) rx_oor = 1'b1; else tx_oor = 1'b1;
    end
    @(negedge clk);
    req_if.REQ_VALID = 1'b0;
    pulses = 0; loads = 0; got = 0; prev_move = 0; oor_clr_t = -1;
    chk("ready_busy", req_if.REQ_READY, 0);
    for (int t = 1; t <= 3000; t++) begin
      if (t == oor_clr_t) begin
        if (s) tx_oor = 1'b0; else rx_oor = 1'b0;
      end
      if (move_o === 1'b1 || load_o === 1'b1) begin
        chk("pulse_cycle", t, 2 + PC + (pulses + loads) * (1 + G));
        chk("pause_at_pulse", pause_o, 1);
        chk("sel_at_pulse", sel_o, s);
        if (move_o === 1'b1) begin
          chk("dir_at_move", dir_o, exp_dir);
          chk("move_spacing", prev_move, 0);
          pulses++;
        end else loads++;
        if (pulses + loads == oor_p) begin
          if (s) tx_oor = 1'b1; else rx_oor = 1'b1;
          oor_clr_t = t + 2;
        end
      end
      if (done_o === 1'b1 || err_o === 1'b1) begin
        got = 1;
        chk("end_cycle", t, exp_end);
        chk("err_flag", err_o, exp_err);
        chk("done_flag", done_o, !exp_err);
        chk("pause_at_end", pause_o, 0);
        if (rej) begin
          chk("sel_kept", sel_o, sel_last);
          chk("dir_kept", dir_o, dir_last);
        end
      end else if (!rej && t < exp_end) begin
        chk("pause_hold", pause_o, 1);
      end
      prev_move = move_o;
      if (got) break;
      @(negedge clk);
    end
    chk("completed", got, 1);
    chk("move_pulses", pulses, moves);
    chk("load_pulses", loads, exp_loads);
    if (!rej) begin
      tap_m[s] = tap;
      sel_last = s;
      if (c != 2'b01) dir_last = exp_dir;
    end
    chk("rx_tap", rx_tap, tap_m[0]);
    chk("tx_tap", tx_tap, tap_m[1]);
    rx_oor = 1'b0; tx_oor = 1'b0;
    @(negedge clk);
    chk("ready_after", req_if.REQ_READY, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, pulses;
    bit [1:0] c;
    int r, cnt;
    rst = 1'b1;
    rx_oor = 1'b0; tx_oor = 1'b0;
    req_if.REQ_VALID = 1'b0; req_if.REQ_SEL = 1'b0; req_if.REQ_CMD = 2'b00;
    req_if.REQ_DIR = 1'b0; req_if.REQ_COUNT = '0;
    tap_m[0] = LV; tap_m[1] = LV; sel_last = 0; dir_last = 0;

    @(negedge clk);
    chk("rst_ready", req_if.REQ_READY, 1);
    chk("rst_pause", pause_o, 0);
    chk("rst_move", move_o, 0);
    chk("rst_load", load_o, 0);
    chk("rst_sel", sel_o, 0);
    chk("rst_dir", dir_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rx_tap", rx_tap, LV);
    chk("rst_tx_tap", tx_tap, LV);
    rst = 1'b0;

    run_req(0, 2'b00, 1, 3,   0, 0);   // RX move up 3
    run_req(1, 2'b10, 0, 10,  0, 0);   // TX set 10
    run_req(1, 2'b10, 0, 4,   0, 0);   // TX set 4 (down)
    run_req(0, 2'b10, 0, 200, 0, 0);
    run_req(0, 2'b01, 0, 0,   0, 0);   // LOAD after tap 200
    run_req(0, 2'b10, 0, 0,   0, 0);
    run_req(0, 2'b00, 0, 2,   0, 0);   // move down from tap 0
    run_req(0, 2'b10, 0, 300, 0, 0);   // target above TAP_MAX
    run_req(1, 2'b11, 1, 5,   0, 0);   // illegal command
    run_req(1, 2'b00, 1, 5,   2, 1);   // TX OOR after 2nd pulse, RX OOR held
    run_req(1, 2'b00, 1, 2,   0, 1);   // RX OOR during TX request
    run_req(1, 2'b10, 0, 255, 0, 0);
    run_req(1, 2'b00, 1, 1,   0, 0);   // move up at TAP_MAX
    run_req(1, 2'b00, 1, 0,   0, 0);   // zero-step move
    run_req(0, 2'b01, 0, 0,   1, 0);   // OOR during LOAD gap

    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 9);
      c = (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      cnt = (c == 2'b10) ? $urandom_range(0, 300) : $urandom_range(0, 6);
      run_req(1'($urandom_range(0, 1)), c, 1'($urandom_range(0, 1)), cnt,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
              1'($urandom_range(0, 1)));
    end

    // Reset in the second gap of a 5-step move, REQ_VALID held high throughout
    @(negedge clk);
    req_if.REQ_VALID = 1'b1; req_if.REQ_SEL = 1'b0; req_if.REQ_CMD = 2'b00;
    req_if.REQ_DIR = 1'b1; req_if.REQ_COUNT = TW'(5);
    k = cyc; pulses = 0;
    @(negedge clk);
    for (int t = 1; t <= 40; t++) begin
      if (move_o === 1'b1) begin
        chk("held_valid_pulse_cycle", t, 2 + PC + pulses * (1 + G));
        pulses++;
      end
      if (t == 2 + PC + (1 + G) + 2) break;
      @(negedge clk);
    end
    chk("pulses_before_reset", pulses, 2);
    chk("pause_before_reset", pause_o, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_pause", pause_o, 0);
    chk("rst_mid_move", move_o, 0);
    chk("rst_mid_load", load_o, 0);
    chk("rst_mid_done", done_o, 0);
    chk("rst_mid_err", err_o, 0);
    chk("rst_mid_rx_tap", rx_tap, LV);
    chk("rst_mid_tx_tap", tx_tap, LV);
    @(negedge clk);
    req_if.REQ_VALID = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("post_rst_done", done_o, 0);
      chk("post_rst_err", err_o, 0);
      chk("post_rst_move", move_o, 0);
    end
    chk("post_rst_ready", req_if.REQ_READY, 1);
    tap_m[0] = LV; tap_m[1] = LV; sel_last = 0; dir_last = 0;
    run_req(0, 2'b00, 1, 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
